// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
//   arb_state_t        - arbiter FSM encoding (IDLE, SEND, WAIT)
//   UART_FRAME_W       - width of one frame presented to the transmitter
//   UART_ARB_N_REQ_DEF - default requester count for the TX arbiter
//   rr_next()          - round-robin successor of an index, wrapping at n-1
package uart_pkg;

  localparam int UART_FRAME_W       = 9;
  localparam int UART_ARB_N_REQ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational rotating-priority encoder.
// Ports:
//   req_i    [N-1:0]  request vector
//   ptr_i    [IW-1:0] index with highest priority this cycle
//   onehot_o [N-1:0]  one-hot winner (zero when nothing requests)
//   idx_o    [IW-1:0] binary winner index (zero when nothing requests)
//   any_o             at least one request present
module uart_rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan from the farthest position back toward ptr_i so the last hit
  // written is the first requester at or after ptr_i (modulo N).
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        onehot_o = '0;
        onehot_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % N);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between N_REQ requesters.
// A requester is granted in round-robin order, its frame is registered and
// offered to the transmitter, and the grant is held until tx_done.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_rdy is a combinational one-hot accept strobe raised only in
// IDLE; tx_val/tx_data are registered and held unchanged until tx_rdy.
//
// Optional feature: define UART_TX_ARB_BURST_EN to let the owner keep the
// grant for up to BURST_MAX consecutive frames (lock flag + burst counter).
// Without it every owner sends exactly one frame and BURST_MAX is unused.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_val  [N_REQ]    per-requester frame valid
//   req_data [9*N_REQ]  requester i frame in bits [9i+8:9i]
//   req_rdy  [N_REQ]    one-hot accept strobe
//   tx_val, tx_data     frame toward the transmitter
//   tx_rdy              transmitter accepts a frame
//   tx_done             transmitter finished the stop bits (1-cycle pulse)
//   gnt      [N_REQ]    one-hot current owner, zero in IDLE
//   busy                FSM not in IDLE
//   dbg_state           current FSM state, for observation only
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = UART_ARB_N_REQ_DEF,
  parameter int BURST_MAX = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_val,
  input  logic [UART_FRAME_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]              req_rdy,
  output logic                          tx_val,
  output logic [UART_FRAME_W-1:0]       tx_data,
  input  logic                          tx_rdy,
  input  logic                          tx_done,
  output logic [N_REQ-1:0]              gnt,
  output logic                          busy,
  output arb_state_t                    dbg_state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t              state_q;
  logic [IW-1:0]           owner_q;
  logic [IW-1:0]           rr_ptr_q;
  logic [UART_FRAME_W-1:0] tx_data_q;
  logic                    tx_val_q;
  logic [N_REQ-1:0]        gnt_q;
  logic                    busy_q;

  logic [N_REQ-1:0]        pick_onehot;
  logic [IW-1:0]           pick_idx;
  logic                    pick_any;

  logic                    lock_hold;   // locked owner still requesting
  logic                    lock_drop;   // locked owner went away
  logic [IW-1:0]           sel_idx;
  logic                    sel_any;
  logic                    grant;
  logic [UART_FRAME_W-1:0] sel_data;
  logic [IW-1:0]           rr_ptr_d;

  uart_rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
    .req_i    (req_val),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

`ifdef UART_TX_ARB_BURST_EN
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  logic          lock_q;
  logic [BW-1:0] bcnt_q;
  logic          burst_more;

  assign lock_hold  = lock_q &  req_val[owner_q];
  assign lock_drop  = lock_q & ~req_val[owner_q];
  assign burst_more = req_val[owner_q] && (int'(bcnt_q) < BURST_MAX - 1);
`else
  logic unused_burst;
  assign unused_burst = (BURST_MAX > 0) ^ (^pick_onehot);
  assign lock_hold    = 1'b0;
  assign lock_drop    = 1'b0;
`endif

  // A released lock suppresses the grant for one cycle so the pointer can
  // move past the old owner before anyone new is picked.
  assign sel_idx  = lock_hold ? owner_q : pick_idx;
  assign sel_any  = lock_hold | (pick_any & ~lock_drop);
  assign grant    = (state_q == IDLE) && sel_any;
  assign sel_data = req_data[int'(sel_idx)*UART_FRAME_W +: UART_FRAME_W];
  assign req_rdy  = grant ? (N_REQ'(1) << sel_idx) : '0;
  assign rr_ptr_d = IW'(rr_next(int'(owner_q), N_REQ));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      tx_data_q <= '0;
      tx_val_q  <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
`ifdef UART_TX_ARB_BURST_EN
      lock_q    <= 1'b0;
      bcnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef UART_TX_ARB_BURST_EN
          if (lock_drop) begin
            lock_q   <= 1'b0;
            bcnt_q   <= '0;
            rr_ptr_q <= rr_ptr_d;
          end
`endif
          if (grant) begin
            tx_data_q <= sel_data;
            owner_q   <= sel_idx;
            gnt_q     <= req_rdy;
            tx_val_q  <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (tx_rdy) begin
            tx_val_q <= 1'b0;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef UART_TX_ARB_BURST_EN
            if (burst_more) begin
              lock_q <= 1'b1;
              bcnt_q <= bcnt_q + BW'(1);
            end else begin
              lock_q   <= 1'b0;
              bcnt_q   <= '0;
              rr_ptr_q <= rr_ptr_d;
            end
`else
            rr_ptr_q <= rr_ptr_d;
`endif
          end
        end
        default: begin
          tx_val_q <= 1'b0;
          gnt_q    <= '0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign tx_val    = tx_val_q;
  assign tx_data   = tx_data_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter (N_REQ=4).
// Every frame handed to the transmitter is matched against exp_q entries
// of {expected gnt, expected frame}; pointwise checks cover the handshake
// timing, backpressure, reset and withdrawal cases.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

`ifdef UART_TX_ARB_BURST_EN
  localparam int BMAX = 3;
`else
  localparam int BMAX = 4;
`endif
  localparam int N  = 4;
  localparam int SW = N + UART_FRAME_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      reset = 1'b1;
  logic [N-1:0]              req_val = '0;
  logic [UART_FRAME_W*N-1:0] req_data = '0;
  logic [N-1:0]              req_rdy;
  logic                      tx_val;
  logic [UART_FRAME_W-1:0]   tx_data;
  logic                      tx_rdy = 1'b0;
  logic                      tx_done = 1'b0;
  logic [N-1:0]              gnt;
  logic                      busy;
  arb_state_t                dbg_state;

  uart_tx_arbiter #(.N_REQ(N), .BURST_MAX(BMAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_data  (req_data),
    .req_rdy   (req_rdy),
    .tx_val    (tx_val),
    .tx_data   (tx_data),
    .tx_rdy    (tx_rdy),
    .tx_done   (tx_done),
    .gnt       (gnt),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int frames   = 0;
  int done_dly = 0;
  int done_cnt = 0;
  logic man_done = 1'b0;
  logic [SW-1:0] exp_q[$];

  // ---------------- scoreboard / transmitter model ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [UART_FRAME_W-1:0] d);
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    exp_q.push_back({oh, d});
  endtask

  // Inputs change only at negedge; +2 later they are stable for the next edge.
  always @(negedge clk) begin
    logic [SW-1:0] e;
    tx_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) tx_done = 1'b1;
    end
    if (man_done) begin
      tx_done  = 1'b1;
      man_done = 1'b0;
    end
    #2;
    if (tx_val && tx_rdy) begin
      frames++;
      done_cnt = done_dly;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL frame_unexpected observed=%0h expected=none", {gnt, tx_data});
      end else begin
        e = exp_q.pop_front();
        assert ({gnt, tx_data} === e) else begin
          failures++;
          $error("FAIL frame observed=%0h expected=%0h", {gnt, tx_data}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_data(input int i, input logic [UART_FRAME_W-1:0] d);
    req_data[i*UART_FRAME_W +: UART_FRAME_W] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_val = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frames < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("frame_count", frames, n);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("reach_idle", busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  int rr_ord[$];
  int bu_ord[$];

  initial begin
`ifdef UART_TX_ARB_BURST_EN
    rr_ord = '{0, 0, 0, 1, 1};
    bu_ord = '{2, 2, 2, 3, 3, 3, 2};
`else
    rr_ord = '{0, 1, 2, 3, 0};
    bu_ord = '{2, 3, 2, 3};
`endif

    // Reset state
    do_reset();
    #1;
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_tx_val", tx_val, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, IDLE);

    // Single request from requester 1
    @(negedge clk);
    tx_rdy = 1'b1; done_dly = 3; frames = 0;
    req_val = 4'b0010; set_data(1, 9'h0A5);
    #1;
    chk("single_req_rdy_c0", req_rdy, 4'b0010);
    chk("single_gnt_c0", gnt, 0);
    push_exp(1, 9'h0A5);
    @(negedge clk);
    req_val = '0;
    #1;
    chk("single_tx_val_c1", tx_val, 1);
    chk("single_tx_data_c1", tx_data, 9'h0A5);
    chk("single_gnt_c1", gnt, 4'b0010);
    chk("single_busy_c1", busy, 1);
    chk("single_req_rdy_c1", req_rdy, 0);
    @(negedge clk);
    #1;
    chk("single_state_c2", dbg_state, WAIT);
    chk("single_tx_val_c2", tx_val, 0);
    chk("single_gnt_c2", gnt, 4'b0010);
    wait_frames(1, 50);
    wait_idle(50);
    chk("single_gnt_idle", gnt, 0);

    // Round robin, all four requesting continuously
    do_reset();
    frames = 0; done_dly = 10;
    for (int i = 0; i < N; i++) set_data(i, 9'(9'h050 + i));
    foreach (rr_ord[k]) push_exp(rr_ord[k], 9'(9'h050 + rr_ord[k]));
    @(negedge clk);
    req_val = 4'b1111;
    wait_frames(rr_ord.size(), 400);
    req_val = '0;
    wait_idle(50);

    // Backpressure: tx_rdy low for 20 cycles
    @(negedge clk);
    frames = 0; done_dly = 3;
    tx_rdy = 1'b0;
    req_val = 4'b0100; set_data(2, 9'h1C3);
    #1;
    chk("bp_req_rdy_c0", req_rdy, 4'b0100);
    push_exp(2, 9'h1C3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_val = 4'b1111;
      #1;
      chk("bp_tx_val_hold", tx_val, 1);
      chk("bp_tx_data_hold", tx_data, 9'h1C3);
      chk("bp_no_req_rdy", req_rdy, 0);
    end
    @(negedge clk);
    req_val = '0; tx_rdy = 1'b1;
    #1;
    chk("bp_state_send", dbg_state, SEND);
    @(negedge clk);
    #1;
    chk("bp_state_wait", dbg_state, WAIT);
    wait_frames(1, 10);
    wait_idle(50);

    // Reset asserted in WAIT, then a stray tx_done
    @(negedge clk);
    frames = 0; done_dly = 0;
    req_val = 4'b0010; set_data(1, 9'h0C7);
    #1;
    chk("rw_req_rdy", req_rdy, 4'b0010);
    push_exp(1, 9'h0C7);
    @(negedge clk);
    req_val = '0;
    @(negedge clk);
    #1;
    chk("rw_state_wait", dbg_state, WAIT);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rw_req_rdy_rst", req_rdy, 0);
    chk("rw_tx_val_rst", tx_val, 0);
    chk("rw_tx_data_rst", tx_data, 0);
    chk("rw_gnt_rst", gnt, 0);
    chk("rw_busy_rst", busy, 0);
    man_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rw_done_ignored_state", dbg_state, IDLE);
    chk("rw_done_ignored_busy", busy, 0);
    done_dly = 2;
    req_val = 4'b1111; set_data(0, 9'h0AA);
    #1;
    chk("rw_next_grant_req0", req_rdy, 4'b0001);
    push_exp(0, 9'h0AA);
    @(negedge clk);
    req_val = '0;
    wait_frames(2, 10);
    wait_idle(50);

    // Burst behaviour with requesters 2 and 3 always valid
    do_reset();
    frames = 0; done_dly = 3;
    set_data(2, 9'h1E2); set_data(3, 9'h1E3);
    foreach (bu_ord[k]) push_exp(bu_ord[k], 9'(9'h1E0 + bu_ord[k]));
    @(negedge clk);
    req_val = 4'b1100;
    wait_frames(bu_ord.size(), 400);
    req_val = '0;
    wait_idle(50);

    // Requester 0 raises then withdraws while requester 3 is in flight
    @(negedge clk);
    frames = 0; done_dly = 8;
    req_val = 4'b1000; set_data(3, 9'h133); set_data(0, 9'h1FF);
    #1;
    chk("wd_req_rdy_3", req_rdy, 4'b1000);
    push_exp(3, 9'h133);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_val = (i < 2) ? 4'b0001 : 4'b0000;
      #1;
      chk("wd_no_req_rdy", req_rdy, 0);
    end
    wait_frames(1, 20);
    wait_idle(50);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("wd_idle_req_rdy", req_rdy, 0);
      chk("wd_idle_tx_val", tx_val, 0);
    end

    // Final report
    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter (the `uart_tx_controller` frame engine) between `N_REQ` independent requesters. Requesters present 9-bit frames over valid/ready handshakes. The arbiter grants one requester at a time in round-robin order, registers its frame, and drives it to the transmitter. It holds the grant until the transmitter reports the frame has left the line. It sits between the host-side producers and the TX controller inside the UART top level.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2–8).
- `BURST_MAX`, 4, maximum consecutive frames per grant; used only with `UART_TX_ARB_BURST_EN`.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous active-high reset.
- `req_val`  in  N_REQ  per-requester frame valid.
- `req_data`  in  9*N_REQ  per-requester frame; requester i occupies bits [9i+8:9i].
- `req_rdy`  out  N_REQ  one-hot accept strobe.
- `tx_val`  out  1  frame valid toward the transmitter.
- `tx_data`  out  9  registered frame toward the transmitter.
- `tx_rdy`  in  1  transmitter can accept a frame.
- `tx_done`  in  1  one-cycle pulse when the transmitter finishes the stop bits.
- `gnt`  out  N_REQ  one-hot current owner; zero when idle.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SEND, WAIT.
- **IDLE**
  - Winner = first i with `req_val[i]`, scanning from `rr_ptr` upward modulo `N_REQ`.
  - `req_rdy[winner]`=1 combinationally in the same cycle.
  - On the clock edge: `tx_data` <= winner's data, `owner` <= winner, go to SEND.
  - No `req_val` high: stay in IDLE, `req_rdy`=0.
- **SEND**
  - `tx_val`=1 with `tx_data` stable.
  - When `tx_val`&`tx_rdy`, go to WAIT.
  - `tx_done` in SEND is ignored.
- **WAIT**
  - `tx_val`=0.
  - On `tx_done`: `rr_ptr` <= (`owner`+1) mod `N_REQ`, go to IDLE.
- `gnt`=onehot(`owner`) in SEND and WAIT, 0 in IDLE.
- `req_rdy`=0 outside IDLE. A requester's data is sampled only on its `req_rdy` cycle.
- Requesters may drop `req_val` at any time without a transfer. Nothing is consumed unless `req_rdy` was high.
- `tx_done` pulses seen in IDLE are ignored.
- A requester with a frame pending is served within `N_REQ` frames (starvation bound).

## Timing
- Reset values: `req_rdy`=0, `tx_val`=0, `tx_data`=0, `gnt`=0, `busy`=0, `rr_ptr`=0, state IDLE, burst count 0, lock 0.
- Reset mid-frame: the arbiter returns to IDLE on the next edge and the captured frame is dropped. The transmitter is not aborted, and its later `tx_done` is ignored.
- Latency: `req_rdy` in cycle 0; `tx_val` in cycle 1; with `tx_rdy` already high, WAIT in cycle 2.
- Minimum turnaround: IDLE is re-entered the cycle after `tx_done`, and a new `req_rdy` can fire in that cycle.
- `tx_rdy` may stay low indefinitely. `tx_val`/`tx_data` stay asserted and unchanged until the handshake.
- `rr_ptr` wraps from `N_REQ`-1 to 0.

## Configuration
- `UART_TX_ARB_BURST_EN` defined: a burst counter `bcnt` and a `lock` flag are compiled in.
  - On `tx_done`, if `req_val[owner]`=1 and `bcnt` < `BURST_MAX`-1: `lock`<=1, `bcnt`++, `rr_ptr` unchanged.
  - Otherwise: `lock`<=0, `bcnt`<=0, `rr_ptr` advances.
  - In IDLE with `lock`=1 and `req_val[owner]`=1, `owner` wins regardless of `rr_ptr`.
  - In IDLE with `lock`=1 and `req_val[owner]`=0: `lock`<=0, `rr_ptr`<=`owner`+1, no grant in that cycle.
- Undefined: burst length is fixed at 1, `BURST_MAX` is ignored, and no lock/counter flops exist.

## Structure
- Shared `uart_pkg`:
  - `arb_state_t` enum {IDLE, SEND, WAIT}.
  - `UART_FRAME_W`=9.
  - `UART_ARB_N_REQ_DEF`=4.
- One sub-module, `uart_rr_picker`: combinational rotating-priority encoder (`req`, `ptr` -> `onehot`, `idx`, `any`).
- The FSM, registers and burst logic live in `uart_tx_arbiter`.

## Test plan
- Single request: `req_val`=0010, `req_data[1]`=9'h0A5, `tx_rdy`=1.
  - `req_rdy`=0010 in cycle 0; `tx_val`=1 with `tx_data`=9'h0A5 in cycle 1; `gnt`=0010 until `tx_done`.
- All four requesting continuously, `tx_done` 10 cycles after each accept: grant order 0,1,2,3,0; `rr_ptr` wraps to 0.
- Backpressure: `tx_rdy`=0 for 20 cycles after `tx_val` rises.
  - `tx_val`/`tx_data` held constant; no `req_rdy` pulses.
  - `tx_rdy`=1 gives WAIT on the next edge.
- Reset asserted in WAIT, then `tx_done` pulses after release: all outputs are 0 and the `tx_done` is ignored; next grant goes to requester 0.
- Burst (macro defined, `BURST_MAX`=3), requesters 2 and 3 always valid: grants 2,2,2,3,3,3,2. Without the macro: 2,3,2,3.
- Requester withdraws: `req_val[0]` rises then falls before any grant while another frame is in flight; no `req_rdy[0]` pulse and no frame from requester 0.
